// File: rtl/nes_pad_reader.sv
// NES controller poller: drives latch/clock, shifts in 8 buttons, and converts
// new or auto-repeated presses into one-cycle command codes plus a chord reset pulse.
module nes_pad_reader #(
    parameter int POLL_CYC     = 833333,
    parameter int LATCH_CYC    = 600,
    parameter int HALF_CYC     = 300,
    parameter int REPEAT_DELAY = 12,
    parameter int REPEAT_RATE  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [3:0] button_data_out,
    output logic       nes_reset,
    output logic [7:0] buttons_raw
);

    localparam int POLL_W  = $clog2(POLL_CYC + 1);
    localparam int PH_MAX  = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W  = $clog2(REP_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WAIT_LOW,
        PULSE,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [POLL_W-1:0] poll_timer_reg;
    logic [PH_W-1:0]   phase_cnt_reg, phase_cnt_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        shift_reg, shift_next;
    logic              data_meta_reg, data_sync_reg;
    logic              nes_latch_reg, nes_clk_reg;
    logic [3:0]        button_data_out_reg;
    logic              nes_reset_reg;
    logic [7:0]        buttons_raw_reg;
    logic [7:0]        prev_reg;
    logic              first_poll_reg;

    logic              poll_wrap;
    logic              latch_last, half_last;
    logic              poll_done;
    logic [7:0]        pressed, new_press;
    logic [2:0]        rep_due;
    logic [7:0]        fire;
    logic [3:0]        event_code;
    logic              event_reset;

    assign poll_wrap  = (poll_timer_reg == POLL_W'(POLL_CYC - 1));
    assign latch_last = (phase_cnt_reg == PH_W'(LATCH_CYC - 1));
    assign half_last  = (phase_cnt_reg == PH_W'(HALF_CYC - 1));
    assign poll_done  = (state_reg == DONE) && !first_poll_reg;
    assign pressed    = shift_reg;
    assign new_press  = pressed & ~prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_meta_reg <= 1'b1;
            data_sync_reg <= 1'b1;
        end else begin
            data_meta_reg <= nes_data;
            data_sync_reg <= data_meta_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_timer_reg <= '0;
        end else if (poll_wrap) begin
            poll_timer_reg <= '0;
        end else begin
            poll_timer_reg <= poll_timer_reg + POLL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            phase_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            nes_latch_reg <= 1'b0;
            nes_clk_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            nes_latch_reg <= (state_next == LATCH);
            nes_clk_reg   <= (state_next == PULSE);
        end
    end

    // A wrap that lands outside IDLE is ignored, so a late poll simply skips a period.
    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        case (state_reg)
            IDLE: begin
                if (poll_wrap) begin
                    state_next     = LATCH;
                    phase_cnt_next = '0;
                    bit_cnt_next   = '0;
                end
            end
            LATCH: begin
                if (latch_last) begin
                    state_next     = WAIT_LOW;
                    phase_cnt_next = '0;
                end else begin
                    phase_cnt_next = phase_cnt_reg + PH_W'(1);
                end
            end
            WAIT_LOW: begin
                if (half_last) begin
                    shift_next[bit_cnt_reg] = ~data_sync_reg;
                    phase_cnt_next          = '0;
                    state_next              = (bit_cnt_reg == 3'd7) ? DONE : PULSE;
                end else begin
                    phase_cnt_next = phase_cnt_reg + PH_W'(1);
                end
            end
            PULSE: begin
                if (half_last) begin
                    phase_cnt_next = '0;
                    bit_cnt_next   = bit_cnt_reg + 3'd1;
                    state_next     = WAIT_LOW;
                end else begin
                    phase_cnt_next = phase_cnt_reg + PH_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-button hold tracking for Down (bit5), Left (bit6), Right (bit7):
    // count up to the initial delay, then re-arm with the shorter repeat rate.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_repeat
            logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
            logic [HOLD_W-1:0] hold_inc, hold_limit;
            logic              rep_active_reg, rep_active_next;
            logic              due;

            always_comb begin
                hold_inc        = hold_cnt_reg + HOLD_W'(1);
                hold_limit      = rep_active_reg ? HOLD_W'(REPEAT_RATE) : HOLD_W'(REPEAT_DELAY);
                hold_cnt_next   = hold_inc;
                rep_active_next = rep_active_reg;
                due             = 1'b0;
                if (!pressed[5+gi] || new_press[5+gi]) begin
                    hold_cnt_next   = '0;
                    rep_active_next = 1'b0;
                end else if (hold_inc == hold_limit) begin
                    hold_cnt_next   = '0;
                    rep_active_next = 1'b1;
                    due             = 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hold_cnt_reg   <= '0;
                    rep_active_reg <= 1'b0;
                end else if (poll_done) begin
                    hold_cnt_reg   <= hold_cnt_next;
                    rep_active_reg <= rep_active_next;
                end
            end

            assign rep_due[gi] = due;
        end
    endgenerate

    assign fire = new_press | {rep_due, 5'b0};

    always_comb begin
        event_code  = 4'd0;
        event_reset = 1'b0;
        if (pressed[3] && pressed[2] && !(prev_reg[3] && prev_reg[2])) begin
            event_reset = 1'b1;
        end else if (new_press[3]) begin
            event_code = 4'd7;
        end else if (new_press[0]) begin
            event_code = 4'd4;
        end else if (new_press[1]) begin
            event_code = 4'd5;
        end else if (new_press[4]) begin
            event_code = 4'd6;
        end else if (fire[5]) begin
            event_code = 4'd3;
        end else if (fire[6]) begin
            event_code = 4'd1;
        end else if (fire[7]) begin
            event_code = 4'd2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            button_data_out_reg <= 4'd0;
            nes_reset_reg       <= 1'b0;
            buttons_raw_reg     <= 8'd0;
            prev_reg            <= 8'd0;
            first_poll_reg      <= 1'b1;
        end else begin
            button_data_out_reg <= poll_done ? event_code : 4'd0;
            nes_reset_reg       <= poll_done && event_reset;
            if (state_reg == DONE) begin
                buttons_raw_reg <= pressed;
                prev_reg        <= pressed;
                first_poll_reg  <= 1'b0;
            end
        end
    end

    assign nes_latch       = nes_latch_reg;
    assign nes_clk         = nes_clk_reg;
    assign button_data_out = button_data_out_reg;
    assign nes_reset       = nes_reset_reg;
    assign buttons_raw     = buttons_raw_reg;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: a pad model serves button frames, a rule-level model
// queues the expected result of each poll, and a monitor checks each poll window.
module tb_nes_pad_reader;

    localparam int POLL_CYC     = 100;
    localparam int LATCH_CYC    = 6;
    localparam int HALF_CYC     = 3;
    localparam int REPEAT_DELAY = 3;
    localparam int REPEAT_RATE  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       nes_data;
    logic       nes_latch, nes_clk, nes_reset;
    logic [3:0] button_data_out;
    logic [7:0] buttons_raw;

    always #5 clk = ~clk;

    nes_pad_reader #(
        .POLL_CYC(POLL_CYC), .LATCH_CYC(LATCH_CYC), .HALF_CYC(HALF_CYC),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) dut (
        .clk(clk), .reset(reset), .nes_data(nes_data), .nes_latch(nes_latch),
        .nes_clk(nes_clk), .button_data_out(button_data_out),
        .nes_reset(nes_reset), .buttons_raw(buttons_raw)
    );

    // Pad: parallel-load while latched, shift on each rising pad clock, active-low data.
    logic [7:0] pad_buttons = 8'd0;
    logic [7:0] pad_sr = 8'd0;
    logic       pad_clk_d = 1'b0;
    always @(negedge clk) begin
        if (nes_latch) pad_sr <= pad_buttons;
        else if (nes_clk && !pad_clk_d) pad_sr <= {1'b0, pad_sr[7:1]};
        pad_clk_d <= nes_clk;
    end
    assign nes_data = ~pad_sr[0];

    typedef struct {
        logic [3:0] code;
        logic       rst;
        logic [7:0] raw;
    } exp_t;
    exp_t exp_q[$];

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic finish_sim();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    endtask

    task automatic timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out waiting for the DUT", name);
        finish_sim();
    endtask

    // Reference model: held-poll count n per button (0 on the press poll).
    logic       model_first;
    logic [7:0] model_prev;
    int         model_n[8];

    task automatic model_reset();
        model_first = 1'b1;
        model_prev  = 8'd0;
        for (int i = 0; i < 8; i++) model_n[i] = -1;
    endtask

    task automatic model_poll(input logic [7:0] p);
        exp_t e;
        logic [7:0] newp, go;
        e.raw = p; e.code = 4'd0; e.rst = 1'b0;
        newp = p & ~model_prev;
        go = newp;
        if (model_first) begin
            model_first = 1'b0;
            for (int i = 0; i < 8; i++) model_n[i] = p[i] ? 0 : -1;
        end else begin
            for (int i = 5; i < 8; i++) begin
                if (!p[i]) model_n[i] = -1;
                else if (newp[i]) model_n[i] = 0;
                else begin
                    model_n[i] = model_n[i] + 1;
                    if (model_n[i] >= REPEAT_DELAY && (model_n[i] - REPEAT_DELAY) % REPEAT_RATE == 0)
                        go[i] = 1'b1;
                end
            end
            if (p[3] && p[2] && !(model_prev[3] && model_prev[2])) e.rst = 1'b1;
            else if (newp[3]) e.code = 4'd7;
            else if (newp[0]) e.code = 4'd4;
            else if (newp[1]) e.code = 4'd5;
            else if (newp[4]) e.code = 4'd6;
            else if (go[5])   e.code = 4'd3;
            else if (go[6])   e.code = 4'd1;
            else if (go[7])   e.code = 4'd2;
        end
        model_prev = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_latch(input logic level);
        int n;
        n = 0;
        @(negedge clk);
        while (nes_latch !== level) begin
            n++;
            if (n > 3 * POLL_CYC) timeout("latch_wait");
            @(negedge clk);
        end
    endtask

    task automatic do_poll(input logic [7:0] p);
        pad_buttons = p;
        model_poll(p);
        wait_latch(1'b1);
        wait_latch(1'b0);
    endtask

    // Monitor: one window per poll, from a latch rise to the next latch rise or reset.
    int         cyc = 0, poll_no = 0;
    logic       win_open = 1'b0, abort_flag = 1'b0, after_reset = 1'b0;
    int         ev_cycles, ev_code, rst_cycles, latch_len, clk_pulses, bad_width, hi_len;
    logic       latch_d = 1'b0, clk_d = 1'b0;
    logic [7:0] raw_last = 8'd0;

    task automatic close_window();
        exp_t e;
        poll_no++;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL exp_queue: poll %0d completed with no expectation queued", poll_no);
        end else begin
            e = exp_q.pop_front();
            $display("poll %0d: raw=%h code=%0d nes_reset=%0d (expect raw=%h code=%0d nes_reset=%0d)",
                     poll_no, raw_last, ev_code, rst_cycles, e.raw, e.code, e.rst);
            check("event_cycles", ev_cycles, (e.code != 4'd0) ? 1 : 0);
            check("event_code", ev_code, e.code);
            check("nes_reset_cycles", rst_cycles, e.rst);
            check("buttons_raw", raw_last, e.raw);
            check("latch_len", latch_len, LATCH_CYC);
            check("clk_pulses", clk_pulses, 7);
            check("clk_width_errs", bad_width, 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (win_open) begin
                    if (abort_flag) abort_flag = 1'b0;
                    else close_window();
                end
                win_open = 1'b0; cyc = 0; after_reset = 1'b1;
                latch_d = 1'b0; clk_d = 1'b0; hi_len = 0;
            end else begin
                cyc++;
                if (nes_latch && !latch_d) begin
                    if (win_open) close_window();
                    if (after_reset) begin
                        check("first_latch_cycle", cyc, POLL_CYC);
                        after_reset = 1'b0;
                    end
                    win_open = 1'b1;
                    ev_cycles = 0; ev_code = 0; rst_cycles = 0;
                    latch_len = 0; clk_pulses = 0; bad_width = 0; hi_len = 0;
                end
                if (win_open) begin
                    if (nes_latch) latch_len++;
                    if (nes_clk) begin
                        if (!clk_d) clk_pulses++;
                        hi_len++;
                    end else if (clk_d) begin
                        if (hi_len != HALF_CYC) bad_width++;
                        hi_len = 0;
                    end
                    if (button_data_out != 4'd0) begin
                        ev_cycles++;
                        ev_code = button_data_out;
                    end
                    if (nes_reset) rst_cycles++;
                end
                latch_d = nes_latch; clk_d = nes_clk; raw_last = buttons_raw;
            end
        end
    end

    initial begin
        logic [7:0] p, mask;
        int n;
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {nes_latch, nes_clk, nes_reset, button_data_out, buttons_raw}, 0);
        reset = 1'b0;

        do_poll(8'h00);
        repeat (3) do_poll(8'h01);
        do_poll(8'h00);
        repeat (8) do_poll(8'h40);
        do_poll(8'h00);
        do_poll(8'h40);
        do_poll(8'h00);
        repeat (3) do_poll(8'h11);
        do_poll(8'h00);

        // Chord, then a reset pulse between polls while the chord stays held.
        do_poll(8'h0C);
        repeat (60) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) do_poll(8'h0C);
        do_poll(8'h00);

        p = 8'h00;
        repeat (40) begin
            for (int i = 0; i < 8; i++) mask[i] = ($urandom_range(0, 3) == 0);
            p = p ^ mask;
            do_poll(p);
        end

        // Reset in the middle of a pad clock pulse; that frame is never queued.
        pad_buttons = 8'hA5;
        abort_flag = 1'b1;
        wait_latch(1'b1);
        n = 0;
        while (nes_clk !== 1'b1) begin
            n++;
            if (n > 3 * POLL_CYC) timeout("pulse_wait");
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check("pads_low_on_reset", {nes_latch, nes_clk}, 0);
        check("raw_cleared_on_reset", buttons_raw, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (5) do_poll(8'hA5);

        wait_latch(1'b1);
        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        finish_sim();
    end

endmodule
